sc_max7219_rx: RTL and testbench

Serial receiver for the MAX7219 LED-matrix protocol: captures DIN/CLK/NCS frames and decodes them into an 8x8 row buffer plus control registers. It is the display-side counterpart of the matrix controller already in the system. It mirrors the matrix image for on-chip checking and provides a synthesizable stand-in for the MAX7219 in board loopback tests. It runs entirely in the 50 MHz system clock domain and oversamples the serial lines.

---
 rtl/sc_max7219_pkg.sv | 32 +++
 rtl/sc_sync_edge.sv | 36 +++
 rtl/sc_max7219_rx.sv | 178 +++++++++++++++++
 tb/tb_sc_max7219_rx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_max7219_pkg.sv
// Shared constants for the MAX7219 serial receiver: register map, frame fields, FSM encoding.
package sc_max7219_pkg;

  // Register addresses carried in frame bits 11:8
  localparam logic [3:0] AddrNoop      = 4'h0;
  localparam logic [3:0] AddrDigit0    = 4'h1;
  localparam logic [3:0] AddrDigit1    = 4'h2;
  localparam logic [3:0] AddrDigit2    = 4'h3;
  localparam logic [3:0] AddrDigit3    = 4'h4;
  localparam logic [3:0] AddrDigit4    = 4'h5;
  localparam logic [3:0] AddrDigit5    = 4'h6;
  localparam logic [3:0] AddrDigit6    = 4'h7;
  localparam logic [3:0] AddrDigit7    = 4'h8;
  localparam logic [3:0] AddrDecode    = 4'h9;
  localparam logic [3:0] AddrIntensity = 4'hA;
  localparam logic [3:0] AddrScanLimit = 4'hB;
  localparam logic [3:0] AddrShutdown  = 4'hC;
  localparam logic [3:0] AddrTest      = 4'hF;

  // Field positions within the 16-bit frame; bits 15:12 are don't-care
  localparam int unsigned AddrMsb = 11;
  localparam int unsigned AddrLsb = 8;
  localparam int unsigned DataMsb = 7;
  localparam int unsigned DataLsb = 0;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLatch
  } state_e;

endpackage

// File: rtl/sc_sync_edge.sv
// Multi-stage synchronizer with registered rise/fall pulses on the synchronized level.
module sc_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;

  // Synchronize, keep the previous level, and register one-cycle edge pulses.
  // Reset to 0 so a line held low through reset release does not look like a falling edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
      r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/sc_max7219_rx.sv
// MAX7219-compatible serial receiver: oversamples DIN/CLK/NCS and decodes frames into
// an 8x8 row buffer plus control registers.
module sc_max7219_rx
  import sc_max7219_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = 16
) (
  input  logic       SC_MAX7219RX_CLOCK_50,
  input  logic       SC_MAX7219RX_RESET_InLow,
  input  logic       SC_MAX7219RX_din_In,
  input  logic       SC_MAX7219RX_clk_In,
  input  logic       SC_MAX7219RX_ncs_In,
  input  logic [2:0] SC_MAX7219RX_rdAddr_In,
  output logic [7:0] SC_MAX7219RX_rdData_Out,
  output logic [3:0] SC_MAX7219RX_intensity_Out,
  output logic [2:0] SC_MAX7219RX_scanLimit_Out,
  output logic [7:0] SC_MAX7219RX_decode_Out,
  output logic       SC_MAX7219RX_shutdown_Out,
  output logic       SC_MAX7219RX_test_Out,
  output logic       SC_MAX7219RX_wrStrobe_Out,
  output logic       SC_MAX7219RX_frameDone_Out,
  output logic       SC_MAX7219RX_err_Out
);

  logic w_clk_rise, w_unused_clk_fall, w_ncs_rise, w_ncs_fall;
  logic [SYNC_STAGES-1:0] r_din_sync;
  logic w_din;

  state_e r_state, w_state_next;
  logic   w_clear, w_shift, w_latch;

  logic [15:0] r_sr;
  logic [4:0]  r_count;

  logic [7:0] r_rows [8];
  logic [7:0] r_rd_data, r_decode;
  logic [3:0] r_intensity;
  logic [2:0] r_scan_limit;
  logic       r_shutdown, r_test, r_wr_strobe, r_frame_done, r_err;

  logic       w_frame_ok;
  logic [3:0] w_addr;
  logic [7:0] w_data;
  logic [2:0] w_row_idx;
  logic       w_unused_sr_hi;

  sc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .i_clk  (SC_MAX7219RX_CLOCK_50),
    .i_rst_n(SC_MAX7219RX_RESET_InLow),
    .i_d    (SC_MAX7219RX_clk_In),
    .o_rise (w_clk_rise),
    .o_fall (w_unused_clk_fall)
  );

  sc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .i_clk  (SC_MAX7219RX_CLOCK_50),
    .i_rst_n(SC_MAX7219RX_RESET_InLow),
    .i_d    (SC_MAX7219RX_ncs_In),
    .o_rise (w_ncs_rise),
    .o_fall (w_ncs_fall)
  );

  // DIN needs only the level synchronizer; it is sampled on the synced CLK rising edge.
  always_ff @(posedge SC_MAX7219RX_CLOCK_50 or negedge SC_MAX7219RX_RESET_InLow) begin
    if (!SC_MAX7219RX_RESET_InLow) r_din_sync <= '0;
    else                           r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], SC_MAX7219RX_din_In};
  end
  assign w_din = r_din_sync[SYNC_STAGES-1];

  // FSM state register.
  always_ff @(posedge SC_MAX7219RX_CLOCK_50 or negedge SC_MAX7219RX_RESET_InLow) begin
    if (!SC_MAX7219RX_RESET_InLow) r_state <= StIdle;
    else                           r_state <= w_state_next;
  end

  // Next state and datapath controls; an NCS rise beats a coincident CLK rise.
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_shift      = 1'b0;
    w_latch      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_ncs_fall) begin
          w_state_next = StShift;
          w_clear      = 1'b1;
        end
      end
      StShift: begin
        if (w_ncs_rise)      w_state_next = StLatch;
        else if (w_ncs_fall) w_clear      = 1'b1;
        else if (w_clk_rise) w_shift      = 1'b1;
      end
      StLatch: begin
        w_latch      = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Shift register and saturating bit counter.
  always_ff @(posedge SC_MAX7219RX_CLOCK_50 or negedge SC_MAX7219RX_RESET_InLow) begin
    if (!SC_MAX7219RX_RESET_InLow) begin
      r_sr    <= '0;
      r_count <= '0;
    end else if (w_clear) begin
      r_sr    <= '0;
      r_count <= '0;
    end else if (w_shift) begin
      r_sr    <= {r_sr[14:0], w_din};
      r_count <= (r_count == 5'd31) ? r_count : r_count + 5'd1;
    end
  end

  assign w_frame_ok     = (r_count == 5'(FRAME_BITS));
  assign w_addr         = r_sr[AddrMsb:AddrLsb];
  assign w_data         = r_sr[DataMsb:DataLsb];
  assign w_row_idx      = 3'(w_addr - 4'd1);
  assign w_unused_sr_hi = ^r_sr[15:12];

  // Frame decode into rows/control registers; strobes are one-cycle pulses.
  always_ff @(posedge SC_MAX7219RX_CLOCK_50 or negedge SC_MAX7219RX_RESET_InLow) begin
    if (!SC_MAX7219RX_RESET_InLow) begin
      for (int i = 0; i < 8; i++) r_rows[i] <= '0;
      r_decode     <= '0;
      r_intensity  <= '0;
      r_scan_limit <= '0;
      r_shutdown   <= 1'b1;
      r_test       <= 1'b0;
      r_wr_strobe  <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_wr_strobe  <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
      if (w_latch) begin
        if (w_frame_ok) begin
          r_wr_strobe <= 1'b1;
          case (w_addr)
            AddrDigit0, AddrDigit1, AddrDigit2, AddrDigit3,
            AddrDigit4, AddrDigit5, AddrDigit6, AddrDigit7: begin
              r_rows[w_row_idx] <= w_data;
              if (w_addr == AddrDigit7) r_frame_done <= 1'b1;
            end
            AddrDecode:    r_decode     <= w_data;
            AddrIntensity: r_intensity  <= w_data[3:0];
            AddrScanLimit: r_scan_limit <= w_data[2:0];
            AddrShutdown:  r_shutdown   <= ~w_data[0];
            AddrTest:      r_test       <= w_data[0];
            default: ;
          endcase
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // Registered row read; a same-cycle write shows up one cycle later.
  always_ff @(posedge SC_MAX7219RX_CLOCK_50 or negedge SC_MAX7219RX_RESET_InLow) begin
    if (!SC_MAX7219RX_RESET_InLow) r_rd_data <= '0;
    else                           r_rd_data <= r_rows[SC_MAX7219RX_rdAddr_In];
  end

  assign SC_MAX7219RX_rdData_Out    = r_rd_data;
  assign SC_MAX7219RX_intensity_Out = r_intensity;
  assign SC_MAX7219RX_scanLimit_Out = r_scan_limit;
  assign SC_MAX7219RX_decode_Out    = r_decode;
  assign SC_MAX7219RX_shutdown_Out  = r_shutdown;
  assign SC_MAX7219RX_test_Out      = r_test;
  assign SC_MAX7219RX_wrStrobe_Out  = r_wr_strobe;
  assign SC_MAX7219RX_frameDone_Out = r_frame_done;
  assign SC_MAX7219RX_err_Out       = r_err;

endmodule

// File: tb/tb_sc_max7219_rx.sv
// Self-checking bench for sc_max7219_rx: scoreboarded strobes plus register/readback checks.
module tb_sc_max7219_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       sclk = 1'b0;
  logic       ncs = 1'b1;
  logic [2:0] rd_addr = 3'd0;
  logic [7:0] rd_data, decode;
  logic [3:0] intensity;
  logic [2:0] scan_limit;
  logic       shutdown, test_reg, wr_strobe, frame_done, err;

  typedef struct {
    logic wr;
    logic er;
    logic fd;
  } exp_t;

  typedef struct {
    logic wr;
    logic er;
    logic fd;
    int   cyc;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];
  int   cyc = 0;
  int   ncs_cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every strobe the DUT emits, with the cycle it appeared in.
  always @(negedge clk) begin
    if (wr_strobe || err || frame_done) begin
      obs_t o;
      o.wr  = wr_strobe;
      o.er  = err;
      o.fd  = frame_done;
      o.cyc = cyc;
      obs_q.push_back(o);
    end
  end

  sc_max7219_rx dut (
    .SC_MAX7219RX_CLOCK_50     (clk),
    .SC_MAX7219RX_RESET_InLow  (rst_n),
    .SC_MAX7219RX_din_In       (din),
    .SC_MAX7219RX_clk_In       (sclk),
    .SC_MAX7219RX_ncs_In       (ncs),
    .SC_MAX7219RX_rdAddr_In    (rd_addr),
    .SC_MAX7219RX_rdData_Out   (rd_data),
    .SC_MAX7219RX_intensity_Out(intensity),
    .SC_MAX7219RX_scanLimit_Out(scan_limit),
    .SC_MAX7219RX_decode_Out   (decode),
    .SC_MAX7219RX_shutdown_Out (shutdown),
    .SC_MAX7219RX_test_Out     (test_reg),
    .SC_MAX7219RX_wrStrobe_Out (wr_strobe),
    .SC_MAX7219RX_frameDone_Out(frame_done),
    .SC_MAX7219RX_err_Out      (err)
  );

  task automatic send_bit(input logic b);
    @(negedge clk);
    din = b;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic ncs_low();
    @(negedge clk);
    ncs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic ncs_high();
    repeat (4) @(negedge clk);
    ncs = 1'b1;
    ncs_cyc = cyc + 1;
    repeat (10) @(negedge clk);
  endtask

  // Drive one frame, queue what it should produce, then match against observed strobes.
  task automatic send_frame(input string name, input logic [31:0] word, input int nbits,
                            input logic e_wr, input logic e_er, input logic e_fd);
    exp_t e;
    obs_t o;
    if (e_wr || e_er) begin
      e.wr = e_wr;
      e.er = e_er;
      e.fd = e_fd;
      exp_q.push_back(e);
    end
    ncs_low();
    for (int i = nbits - 1; i >= 0; i--) send_bit(word[i]);
    ncs_high();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s strobe: got none, want wr=%0b err=%0b fd=%0b", name, e.wr, e.er, e.fd);
      end else begin
        o = obs_q.pop_front();
        if (o.wr !== e.wr || o.er !== e.er || o.fd !== e.fd) begin
          errors++;
          $display("FAIL %s strobe: got wr=%0b err=%0b fd=%0b, want wr=%0b err=%0b fd=%0b",
                   name, o.wr, o.er, o.fd, e.wr, e.er, e.fd);
        end
        checks++;
        if (o.cyc - ncs_cyc !== 4) begin
          errors++;
          $display("FAIL %s latency: got %0d, want 4", name, o.cyc - ncs_cyc);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL %s extra strobes: got %0d, want 0", name, obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (intensity !== 4'h0 || scan_limit !== 3'h0 || decode !== 8'h00 || shutdown !== 1'b1 ||
        test_reg !== 1'b0 || wr_strobe !== 1'b0 || frame_done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset regs: got int=%h scan=%h dec=%h sd=%b tst=%b wr=%b fd=%b err=%b, want 0 0 00 1 0 0 0 0",
               intensity, scan_limit, decode, shutdown, test_reg, wr_strobe, frame_done, err);
    end
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      @(negedge clk);
      checks++;
      if (rd_data !== 8'h00) begin
        errors++;
        $display("FAIL reset row%0d: got %h, want 00", i, rd_data);
      end
    end
  endtask

  task automatic test_single_row();
    send_frame("row2", 32'h0318, 16, 1'b1, 1'b0, 1'b0);
    rd_addr = 3'd2;
    @(negedge clk);
    checks++;
    if (rd_data !== 8'h18) begin
      errors++;
      $display("FAIL row2 read: got %h, want 18", rd_data);
    end
  endtask

  task automatic test_all_rows();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] w;
      w = {16'h0, 4'h0, 4'(i + 1), 8'(8'h81 + i)};
      send_frame("rows", w, 16, 1'b1, 1'b0, (i == 7));
    end
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      @(negedge clk);
      checks++;
      if (rd_data !== 8'(8'h81 + i)) begin
        errors++;
        $display("FAIL rows row%0d: got %h, want %h", i, rd_data, 8'(8'h81 + i));
      end
    end
  endtask

  task automatic test_control();
    send_frame("intensity", 32'h0A0A, 16, 1'b1, 1'b0, 1'b0);
    send_frame("scanlimit", 32'h0B07, 16, 1'b1, 1'b0, 1'b0);
    send_frame("shutdown0", 32'h0C01, 16, 1'b1, 1'b0, 1'b0);
    send_frame("decode", 32'h09FF, 16, 1'b1, 1'b0, 1'b0);
    checks++;
    if (intensity !== 4'hA || scan_limit !== 3'h7 || shutdown !== 1'b0 || decode !== 8'hFF) begin
      errors++;
      $display("FAIL ctrl: got int=%h scan=%h sd=%b dec=%h, want a 7 0 ff",
               intensity, scan_limit, shutdown, decode);
    end
    send_frame("shutdown1", 32'h0C00, 16, 1'b1, 1'b0, 1'b0);
    checks++;
    if (shutdown !== 1'b1) begin
      errors++;
      $display("FAIL shutdown1: got %b, want 1", shutdown);
    end
    send_frame("test", 32'h0F01, 16, 1'b1, 1'b0, 1'b0);
    checks++;
    if (test_reg !== 1'b1) begin
      errors++;
      $display("FAIL test reg: got %b, want 1", test_reg);
    end
  endtask

  task automatic test_bad_count();
    send_frame("bits15", 32'h0A03, 15, 1'b0, 1'b1, 1'b0);
    send_frame("bits17", 32'h0A03, 17, 1'b0, 1'b1, 1'b0);
    rd_addr = 3'd0;
    @(negedge clk);
    checks++;
    if (intensity !== 4'hA || rd_data !== 8'h81) begin
      errors++;
      $display("FAIL badcount regs: got int=%h row0=%h, want a 81", intensity, rd_data);
    end
  endtask

  task automatic test_noop();
    send_frame("noop", 32'h0000, 16, 1'b1, 1'b0, 1'b0);
    rd_addr = 3'd7;
    @(negedge clk);
    checks++;
    if (intensity !== 4'hA || scan_limit !== 3'h7 || decode !== 8'hFF || shutdown !== 1'b1 ||
        test_reg !== 1'b1 || rd_data !== 8'h88) begin
      errors++;
      $display("FAIL noop regs: got int=%h scan=%h dec=%h sd=%b tst=%b row7=%h, want a 7 ff 1 1 88",
               intensity, scan_limit, decode, shutdown, test_reg, rd_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] w;
    w = 16'h0255;
    ncs_low();
    for (int i = 15; i >= 8; i--) send_bit(w[i]);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
    ncs_high();
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL midreset strobes: got %0d, want 0", obs_q.size());
      obs_q.delete();
    end
    test_reset();
    send_frame("after_reset", 32'h0255, 16, 1'b1, 1'b0, 1'b0);
    rd_addr = 3'd1;
    @(negedge clk);
    checks++;
    if (rd_data !== 8'h55) begin
      errors++;
      $display("FAIL after_reset row1: got %h, want 55", rd_data);
    end
  endtask

  initial begin
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    test_reset();
    test_single_row();
    test_all_rows();
    test_control();
    test_bad_count();
    test_noop();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
